// File: rtl/mem_line_responder_pkg.sv
// rtl/mem_line_responder_pkg.sv - shared types and constants for the line responder
package mem_line_responder_pkg;

  localparam int LINE_BITS       = 256;
  localparam int ADDR_BITS       = 32;
  localparam int OFFSET_BITS     = 5;
  localparam int DEFAULT_LATENCY = 10;
  localparam int DEFAULT_DEPTH   = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_line_array.sv
// rtl/mem_line_array.sv - single-port line storage with registered read data
module mem_line_array
  import mem_line_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [LINE_BITS-1:0]     wdata_i,
  output logic [LINE_BITS-1:0]     rdata_o
);

  logic [LINE_BITS-1:0] mem [DEPTH];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem[idx_i];
    end
  end

endmodule

// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - fixed-latency line read/write responder
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = DEFAULT_DEPTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [LINE_BITS-1:0] data_i,
  input  logic                 enable_i,
  input  logic                 write_i,
  output logic                 ack_o,
  output logic [LINE_BITS-1:0] data_o
);

  localparam int IDX_BITS = $clog2(DEPTH);

  state_e               state_q;
  state_e               state_d;
  logic [7:0]           cnt_q;
  logic [IDX_BITS-1:0]  idx_q;
  logic [LINE_BITS-1:0] wdata_q;
  logic                 write_q;
  logic                 accept;
  logic                 complete;
  logic                 mem_we;
  logic                 mem_re;

  logic unused_addr;
  assign unused_addr = ^{addr_i[ADDR_BITS-1:OFFSET_BITS+IDX_BITS], addr_i[OFFSET_BITS-1:0]};

  assign accept   = (state_q == IDLE) && enable_i;
  // The counter is loaded with LATENCY-1 and expires on the LATENCY-th edge.
  assign complete = (state_q == BUSY) && (cnt_q == 8'd0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i) state_d = BUSY;
      BUSY:    if (cnt_q == 8'd0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_o  = (state_q == ACK);
    mem_we = complete && write_q;
    mem_re = complete && !write_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if (accept) begin
      cnt_q   <= 8'(LATENCY - 1);
      idx_q   <= addr_i[OFFSET_BITS +: IDX_BITS];
      wdata_q <= data_i;
      write_q <= write_i;
    end else if ((state_q == BUSY) && (cnt_q != 8'd0)) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  mem_line_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .idx_i  (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(data_o)
  );

endmodule

// File: tb/tb_mem_line_responder.sv
// tb/tb_mem_line_responder.sv - scoreboard bench for mem_line_responder
module tb_mem_line_responder;

  localparam int LAT = 10;

  typedef struct {
    int           ack_cyc;
    logic [255:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] wdata = '0;
  logic         enable = 1'b0;
  logic         write = 1'b0;
  logic         ack_o;
  logic [255:0] data_o;

  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           free_edge = 0;
  logic [255:0] last_rd = '0;
  logic [255:0] model [int];
  exp_t         sb [$];

  mem_line_responder #(
    .LATENCY(LAT),
    .DEPTH  (512)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .addr_i  (addr),
    .data_i  (wdata),
    .enable_i(enable),
    .write_i (write),
    .ack_o   (ack_o),
    .data_o  (data_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  always @(negedge clk) begin
    if (ack_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack_o=1 at cycle %0d with nothing outstanding", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (cyc != e.ack_cyc) begin
          errors++;
          $display("FAIL ack_cycle: got %0d expected %0d", cyc, e.ack_cyc);
        end
        checks++;
        if (data_o !== e.data) begin
          errors++;
          $display("FAIL ack_data: got %h expected %h", data_o, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge where the ack is seen.
  task automatic issue(input logic [31:0] a, input logic [255:0] d, input logic wr,
                       input bit hold, input bit chg);
    int   acc;
    int   idx;
    bit   got;
    exp_t e;
    enable = 1'b1;
    addr   = a;
    wdata  = d;
    write  = wr;
    acc = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
    e.ack_cyc = acc + LAT;
    free_edge = acc + LAT + 2;
    idx = int'((a >> 5) & 32'd511);
    if (wr) begin
      model[idx] = d;
      e.data = last_rd;
    end else begin
      e.data = model[idx];
      last_rd = e.data;
    end
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 4 * LAT && !got; i++) begin
      @(negedge clk);
      if (chg && cyc == acc) begin
        addr  = a + 32'h20;
        wdata = ~d;
      end
      if (ack_o) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no ack for addr %h", a);
    end
    if (!hold) enable = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ack", {255'd0, ack_o}, 256'd0);
    chk("reset_data", data_o, 256'd0);
    rst = 1'b1;
    @(negedge clk);

    // preload lines 3, 2 and 6
    issue(32'h60, {32{8'hA5}}, 1'b1, 1'b0, 1'b0);
    issue(32'h40, {32{8'h55}}, 1'b1, 1'b0, 1'b0);
    issue(32'hC0, {32{8'hE7}}, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    issue(32'h60, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // write then read of the same line, enable held through the ack
    issue(32'h80, 256'h1234, 1'b1, 1'b1, 1'b0);
    issue(32'h9F, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    issue(32'h4000, {32{8'hC3}}, 1'b1, 1'b0, 1'b0);
    issue(32'h0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    issue(32'h60, '0, 1'b0, 1'b1, 1'b0);
    issue(32'h80, '0, 1'b0, 1'b1, 1'b0);
    issue(32'h0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // reset pulse four edges into a write to line 2
    begin
      int acc;
      enable = 1'b1;
      write  = 1'b1;
      addr   = 32'h40;
      wdata  = {32{8'hBD}};
      acc    = cyc + 1;
      @(negedge clk);
      enable = 1'b0;
      while (cyc < acc + 3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_ack", {255'd0, ack_o}, 256'd0);
      chk("midrst_data", data_o, 256'd0);
      @(negedge clk);
      rst = 1'b1;
      free_edge = 0;
      last_rd = '0;
      repeat (2 * LAT) @(negedge clk);
      chk("post_rst_data", data_o, 256'd0);
    end
    issue(32'h40, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // inputs altered the cycle after acceptance must not redirect the write
    issue(32'hA0, {32{8'hD1}}, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    issue(32'hA0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    issue(32'hC0, '0, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL outstanding: %0d expected acks never arrived", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
